// File: rtl/block_assembler.sv
// Packs a stream of WORD_W-bit words, big-endian, into one BLOCK_W-bit block
// and strobes data_load for one cycle when the downstream core can take it.
//
// Ports:
//   clk        - system clock, rising edge
//   n_rst      - asynchronous active-low reset
//   word_in    - input word, captured on accept (word_valid & word_ready)
//   word_valid - source presents a word
//   word_ready - block can take a word this cycle (FILL and no clear)
//   clear      - synchronous flush of a partial or held block
//   core_busy  - downstream cannot take a block this cycle
//   block_out  - assembled block (register)
//   data_load  - one-cycle load strobe, decoded from HOLD state
//   word_count - words held in the current block, 0..WORDS
module block_assembler #(
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned BLOCK_W = 128
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [WORD_W-1:0]  word_in,
    input  logic               word_valid,
    output logic               word_ready,
    input  logic               clear,
    input  logic               core_busy,
    output logic [BLOCK_W-1:0] block_out,
    output logic               data_load,
    output logic [2:0]         word_count
);

    localparam int unsigned WORDS = BLOCK_W / WORD_W;
    localparam int unsigned CNT_W = 3;

    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [BLOCK_W-1:0] block_q, block_d;
    logic               accept;

    // Handshake and strobe are decodes of registered state; clear suppresses both.
    assign word_ready = (state_q == FILL) & ~clear;
    assign data_load  = (state_q == HOLD) & ~core_busy & ~clear;
    assign accept     = word_valid & word_ready;
    assign block_out  = block_q;
    assign word_count = count_q;

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= FILL;
            count_q <= '0;
            block_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            block_q <= block_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        block_d = block_q;
        if (clear) begin
            state_d = FILL;
            count_d = '0;
            block_d = '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept) begin
                        // Shift left so the first word ends up in the top slot.
                        block_d = {block_q[BLOCK_W-WORD_W-1:0], word_in};
                        count_d = count_q + CNT_W'(1);
                        if (count_q == CNT_W'(WORDS - 1)) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!core_busy) begin
                        state_d = FILL;
                        count_d = '0;
                    end
                end
                default: begin
                    state_d = FILL;
                    count_d = '0;
                end
            endcase
        end
    end

endmodule
